// File: rtl/rida_pkg.sv
// Shared fetch/decode definitions: instruction field positions,
// instruction classes and fetch FSM states.
package rida_pkg;

  localparam int INSTR_BYTES = 4;

  localparam int COND_MSB = 31;
  localparam int COND_LSB = 30;
  localparam int TIPO_MSB = 29;
  localparam int TIPO_LSB = 28;
  localparam int OPC_MSB  = 27;
  localparam int OPC_LSB  = 25;
  localparam int FMS_MSB  = 24;
  localparam int FMS_LSB  = 23;

  typedef enum logic [1:0] {
    REG  = 2'd0,
    IMM  = 2'd1,
    MEM  = 2'd2,
    CTRL = 2'd3
  } tipo_e;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_field_split.sv
// Combinational split of an instruction word into the fields
// consumed by the control unit.
module instr_field_split
  import rida_pkg::*;
#(
  parameter int INSTR_WIDTH = 32
) (
  input  logic [INSTR_WIDTH-1:0] instr,
  output logic [1:0]             cond,
  output tipo_e                  tipo,
  output logic [2:0]             opcode,
  output logic [1:0]             flag_mov_shift
);

  assign cond           = instr[COND_MSB:COND_LSB];
  assign tipo           = tipo_e'(instr[TIPO_MSB:TIPO_LSB]);
  assign opcode         = instr[OPC_MSB:OPC_LSB];
  assign flag_mov_shift = instr[FMS_MSB:FMS_LSB];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem requests,
// output register to decode. Optional FETCH_PERF_CNT_EN adds counters.
module fetch_unit
  import rida_pkg::*;
#(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [INSTR_WIDTH-1:0] id_instr,
  output logic [PC_WIDTH-1:0]    id_pc,
  output logic [1:0]             id_cond,
  output logic [1:0]             id_tipo,
  output logic [2:0]             id_opcode,
  output logic [1:0]             id_flag_mov_shift
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            perf_fetch_count,
  output logic [31:0]            perf_stall_count
`endif
);

  localparam logic [PC_WIDTH-1:0] STEP  = PC_WIDTH'(INSTR_BYTES);
  localparam logic [PC_WIDTH-1:0] ALIGN = ~PC_WIDTH'(INSTR_BYTES - 1);

  fetch_state_e state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] id_pc_q, id_pc_d;
  logic [INSTR_WIDTH-1:0] id_instr_q, id_instr_d;
  logic id_valid_q, id_valid_d;
  logic req_fire, id_fire;
  tipo_e tipo;

  assign imem_req_valid = rst_n && (state_q == REQ)
                        && (!id_valid_q || id_ready)
                        && !branch_taken;
  assign imem_addr = pc_q & ALIGN;
  assign req_fire  = imem_req_valid && imem_req_ready;
  assign id_fire   = id_valid_q && id_ready;

  assign id_valid = id_valid_q;
  assign id_instr = id_instr_q;
  assign id_pc    = id_pc_q;
  assign id_tipo  = tipo;

  instr_field_split #(
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_split (
    .instr         (id_instr_q),
    .cond          (id_cond),
    .tipo          (tipo),
    .opcode        (id_opcode),
    .flag_mov_shift(id_flag_mov_shift)
  );

  // Next-state: redirect first, then request/response sequencing
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    if (id_fire) id_valid_d = 1'b0;
    if (branch_taken) begin
      pc_d       = branch_target & ALIGN;
      id_valid_d = 1'b0;
      case (state_q)
        WAIT:    state_d = imem_rsp_valid ? REQ : DROP;
        DROP:    state_d = imem_rsp_valid ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end else begin
      case (state_q)
        REQ: begin
          if (req_fire) begin
            pc_d    = pc_q + STEP;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            id_valid_d = 1'b1;
            id_instr_d = imem_rsp_data;
            id_pc_d    = pc_q - STEP;
            state_d    = REQ;
          end
        end
        DROP: begin
          if (imem_rsp_valid) state_d = REQ;
        end
        default: state_d = REQ;
      endcase
    end
  end

  // State, PC and output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign perf_fetch_count = fetch_cnt_q;
  assign perf_stall_count = stall_cnt_q;

  // Handshake and stall counters, free-running with wrap
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (id_fire) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (id_valid_q && !id_ready) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed phases plus random traffic
// checked against a transaction-level fetch model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [1:0]  id_cond;
  logic [1:0]  id_tipo;
  logic [2:0]  id_opcode;
  logic [1:0]  id_flag_mov_shift;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_count;
  logic [31:0] perf_stall_count;
`endif

  fetch_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_addr        (imem_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .id_valid         (id_valid),
    .id_ready         (id_ready),
    .id_instr         (id_instr),
    .id_pc            (id_pc),
    .id_cond          (id_cond),
    .id_tipo          (id_tipo),
    .id_opcode        (id_opcode),
    .id_flag_mov_shift(id_flag_mov_shift)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_count (perf_fetch_count),
    .perf_stall_count (perf_stall_count)
`endif
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // reference model state
  bit          m_out_v;
  logic [31:0] m_out_instr, m_out_pc;
  bit          m_outst, m_taint;
  logic [31:0] m_pc, m_req_addr;
  logic [31:0] m_fetch_cnt, m_stall_cnt;

  // memory model and stimulus knobs
  int          mem_cnt;
  logic [31:0] mem_data;
  int          p_rdy, p_idr, p_br, p_spur, lat_max;
  bit          force_br, force_spur, force_a5;
  logic [31:0] force_tgt;
  logic [31:0] a5_word;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout(string tag);
    compared++;
    mismatched++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  function automatic logic [31:0] rnd_target();
    if ($urandom_range(3) == 0)
      return 32'hFFFF_FFF0 + 32'($urandom_range(15));
    return 32'($urandom_range(511));
  endfunction

  task automatic check_outputs();
    bit exp_rv;
    exp_rv = rst_n && !m_outst && (!m_out_v || id_ready) && !branch_taken;
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("imem_addr", imem_addr, m_pc);
    chk("id_valid", 32'(id_valid), 32'(m_out_v));
    if (m_out_v) begin
      chk("id_instr", id_instr, m_out_instr);
      chk("id_pc", id_pc, m_out_pc);
      chk("id_cond", 32'(id_cond), 32'(m_out_instr[31:30]));
      chk("id_tipo", 32'(id_tipo), 32'(m_out_instr[29:28]));
      chk("id_opcode", 32'(id_opcode), 32'(m_out_instr[27:25]));
      chk("id_fms", 32'(id_flag_mov_shift), 32'(m_out_instr[24:23]));
      if (m_out_instr == a5_word) begin
        chk("a5_cond", 32'(id_cond), 32'd2);
        chk("a5_tipo", 32'(id_tipo), 32'd2);
        chk("a5_opcode", 32'(id_opcode), 32'd2);
        chk("a5_fms", 32'(id_flag_mov_shift), 32'd2);
      end
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_count, m_fetch_cnt);
    chk("perf_stall", perf_stall_count, m_stall_cnt);
`endif
  endtask

  // advance the model across one clock edge
  task automatic update_model();
    bit acc;
    if (!rst_n) begin
      m_out_v = 0; m_outst = 0; m_taint = 0;
      m_pc = 32'h0; mem_cnt = 0;
      m_fetch_cnt = 0; m_stall_cnt = 0;
      return;
    end
    acc = !m_outst && (!m_out_v || id_ready) && !branch_taken
        && imem_req_ready;
    if (m_out_v && !id_ready) m_stall_cnt++;
    if (m_out_v && id_ready) begin
      m_fetch_cnt++;
      m_out_v = 0;
    end
    if (branch_taken) begin
      m_out_v = 0;
      m_pc = branch_target & ~32'd3;
      if (m_outst) begin
        if (imem_rsp_valid) begin
          m_outst = 0; m_taint = 0;
        end else begin
          m_taint = 1;
        end
      end
    end else if (imem_rsp_valid && m_outst) begin
      if (!m_taint) begin
        m_out_v = 1;
        m_out_instr = imem_rsp_data;
        m_out_pc = m_req_addr;
      end
      m_outst = 0; m_taint = 0;
    end
    if (acc) begin
      m_outst = 1; m_taint = 0;
      m_req_addr = m_pc;
      m_pc = m_pc + 32'd4;
      mem_cnt = $urandom_range(lat_max, 1);
      mem_data = force_a5 ? a5_word : $urandom;
      force_a5 = 0;
    end
  endtask

  task automatic cycle();
    imem_rsp_valid = 0;
    imem_rsp_data = $urandom;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1;
        imem_rsp_data = mem_data;
      end
    end else begin
      imem_rsp_valid = force_spur || (int'($urandom_range(99)) < p_spur);
    end
    force_spur = 0;
    imem_req_ready = int'($urandom_range(99)) < p_rdy;
    id_ready = int'($urandom_range(99)) < p_idr;
    branch_taken = force_br || (int'($urandom_range(99)) < p_br);
    branch_target = force_br ? force_tgt : rnd_target();
    force_br = 0;
    @(negedge clk);
    check_outputs();
    update_model();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a5_word = 32'hA500_0000;
    rst_n = 0; imem_req_ready = 0; imem_rsp_valid = 0;
    imem_rsp_data = 0; branch_taken = 0; branch_target = 0;
    id_ready = 0; mem_cnt = 0; m_pc = 0;
    force_br = 0; force_spur = 0; force_a5 = 0; force_tgt = 0;
    p_rdy = 100; p_idr = 100; p_br = 0; p_spur = 0; lat_max = 1;
    m_out_v = 0; m_outst = 0; m_taint = 0;
    m_fetch_cnt = 0; m_stall_cnt = 0;
    @(posedge clk); #1;
    cycle(); cycle();
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    rst_n = 1;

    // straight-line fetch, 1-cycle memory, first word 0xA5000000
    force_a5 = 1;
    for (int i = 0; i < 12; i++) cycle();

    // decode back-pressure
    p_idr = 0;
    for (int i = 0; i < 8; i++) cycle();
    p_idr = 100;
    for (int i = 0; i < 4; i++) cycle();

    // redirect to 0x103 while a request is outstanding
    lat_max = 3;
    begin
      int n = 0;
      while (!(m_outst && mem_cnt >= 2) && n < 50) begin
        cycle(); n++;
      end
      if (n >= 50) timeout("wait_outst_br");
    end
    force_br = 1; force_tgt = 32'h103;
    for (int i = 0; i < 10; i++) cycle();

    // redirect in the same cycle as the response
    begin
      int n = 0;
      while (mem_cnt != 1 && n < 50) begin
        cycle(); n++;
      end
      if (n >= 50) timeout("wait_rsp_br");
    end
    force_br = 1; force_tgt = 32'h40;
    for (int i = 0; i < 8; i++) cycle();

    // reset while waiting, then a late response
    begin
      int n = 0;
      while (!m_outst && n < 50) begin
        cycle(); n++;
      end
      if (n >= 50) timeout("wait_outst_rst");
    end
    rst_n = 0;
    cycle();
    rst_n = 1;
    force_spur = 1;
    for (int i = 0; i < 8; i++) cycle();

    // random traffic
    p_rdy = 70; p_idr = 60; p_br = 8; p_spur = 10; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst_n = 0;
        cycle();
        rst_n = 1;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
